// File: rtl/dma_pkg.sv
// Shared types and helpers for the strided memory<->buffer DMA.
package dma_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} dma_state_t;
  typedef enum logic {DMA_READ, DMA_WRITE} dma_mode_t;

  localparam int ADDR_MAX_W = 32;

  // Callers truncate the result to their address width, which gives the natural wrap.
  function automatic logic [ADDR_MAX_W-1:0] addr_step(
    input logic [ADDR_MAX_W-1:0] addr,
    input logic [ADDR_MAX_W-1:0] stride
  );
    return addr + stride;
  endfunction

endpackage

// File: rtl/dma_tag_pipe.sv
// Delay line carrying {valid, word index} alongside the memory read latency.
module dma_tag_pipe #(
  parameter int MEM_LATENCY = 0,
  parameter int IDX_W       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
);

  generate
    if (MEM_LATENCY == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_vld = in_vld;
      assign out_idx = in_idx;
      assign busy    = 1'b0;
    end else begin : g_pipe
      logic [MEM_LATENCY-1:0]            vld_pipe;
      logic [MEM_LATENCY-1:0][IDX_W-1:0] idx_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe <= '0;
          idx_pipe <= '0;
        end else begin
          vld_pipe[0] <= in_vld;
          idx_pipe[0] <= in_idx;
          for (int s = 1; s < MEM_LATENCY; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            idx_pipe[s] <= idx_pipe[s-1];
          end
        end
      end

      assign out_vld = vld_pipe[MEM_LATENCY-1];
      assign out_idx = idx_pipe[MEM_LATENCY-1];

      // The last stage is being captured this cycle, so only earlier stages keep us draining.
      always_comb begin
        busy = 1'b0;
        for (int s = 0; s < MEM_LATENCY - 1; s++) busy = busy | vld_pipe[s];
      end
    end
  endgenerate

endmodule

// File: rtl/strided_dma.sv
// Strided DMA between word-addressed memory and a packed word buffer, both directions.
module strided_dma
  import dma_pkg::*;
#(
  parameter int BUFFER_SIZE       = 120,
  parameter int WORD_SIZE         = 16,
  parameter int MEM_ADDRESS_WIDTH = 3,
  parameter int COUNT_WIDTH       = $clog2(BUFFER_SIZE + 1),
  parameter int MEM_LATENCY       = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_start,
  input  logic                                  i_write,
  input  logic [MEM_ADDRESS_WIDTH-1:0]          i_address,
  input  logic [MEM_ADDRESS_WIDTH-1:0]          i_stride,
  input  logic [COUNT_WIDTH-1:0]                i_count,
  input  logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] i_buffer,
  input  logic [WORD_SIZE-1:0]                  i_mem_data,
  output logic [MEM_ADDRESS_WIDTH-1:0]          o_mem_addr,
  output logic                                  o_mem_write,
  output logic [WORD_SIZE-1:0]                  o_mem_data,
  output logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] o_buffer,
  output logic                                  o_ready,
  output logic                                  o_done
);

  localparam int IDX_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  dma_state_t                           state, state_nxt;
  dma_mode_t                            mode_q;
  logic [MEM_ADDRESS_WIDTH-1:0]         addr_q, stride_q;
  logic [IDX_W-1:0]                     k_q, last_q;
  logic [COUNT_WIDTH-1:0]               clamped;
  logic                                 start_ok, last_word;
  logic                                 tag_in_vld, tag_out_vld, tag_busy;
  logic [IDX_W-1:0]                     tag_out_idx;
  logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] buf_q;

  assign clamped   = (i_count > COUNT_WIDTH'(BUFFER_SIZE)) ? COUNT_WIDTH'(BUFFER_SIZE) : i_count;
  assign start_ok  = (state == IDLE) && i_start;
  assign last_word = (k_q == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_mem_write = 1'b0;
    o_mem_data  = '0;
    tag_in_vld  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) state_nxt = (clamped == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (mode_q == DMA_WRITE) begin
          o_mem_write = 1'b1;
          o_mem_data  = i_buffer[k_q];
        end else begin
          tag_in_vld = 1'b1;
        end
        if (last_word)
          state_nxt = (mode_q == DMA_WRITE || MEM_LATENCY == 0) ? DONE : DRAIN;
      end
      DRAIN: if (!tag_busy) state_nxt = DONE;
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The address register doubles as the output so it holds its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
      mode_q   <= DMA_READ;
      k_q      <= '0;
      last_q   <= '0;
    end else if (start_ok && clamped != '0) begin
      addr_q   <= i_address;
      stride_q <= i_stride;
      mode_q   <= dma_mode_t'(i_write);
      k_q      <= '0;
      last_q   <= IDX_W'(clamped - 1'b1);
    end else if (state == ISSUE && !last_word) begin
      addr_q <= MEM_ADDRESS_WIDTH'(addr_step(ADDR_MAX_W'(addr_q), ADDR_MAX_W'(stride_q)));
      k_q    <= k_q + 1'b1;
    end
  end

  dma_tag_pipe #(
    .MEM_LATENCY (MEM_LATENCY),
    .IDX_W       (IDX_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (tag_in_vld),
    .in_idx  (k_q),
    .out_vld (tag_out_vld),
    .out_idx (tag_out_idx),
    .busy    (tag_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           buf_q <= '0;
    else if (tag_out_vld) buf_q[tag_out_idx] <= i_mem_data;
  end

  assign o_mem_addr = addr_q;
  assign o_buffer   = buf_q;

endmodule
